// File: rtl/axis_mon_pkg.sv
// Shared definitions for the AXI-stream deadlock monitors: stall classification
// and small elaboration helpers.
package axis_mon_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_STALL = 2'd2
  } stall_type_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Read-side observers see starvation, write-side observers see back-pressure.
  function automatic stall_type_e classify(input logic valid, input logic ready,
                                           input logic is_read);
    if (valid && ready)                  return ST_XFER;
    else if (is_read && ready && !valid) return ST_STALL;
    else if (!is_read && valid && !ready) return ST_STALL;
    else                                 return ST_IDLE;
  endfunction

endpackage

// File: rtl/axis_stall_counter.sv
// Per-channel saturating stall counter with registered blocked flag.
module axis_stall_counter
  import axis_mon_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int STALL_THRESH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic             ready,
  input  logic             is_read,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_next,
  output logic [CNT_W-1:0] cnt,
  output logic             flag
);

  localparam logic [CNT_W-1:0] THR     = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stall_type_e st;

  assign st = classify(valid, ready, is_read);

  always_comb begin
    cnt_next = cnt;
    if (clear)
      cnt_next = '0;
    else if (enable) begin
      if (st == ST_STALL)
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      else
        cnt_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (enable) begin
      cnt  <= cnt_next;
      flag <= (cnt_next >= THR);
    end
  end

endmodule

// File: rtl/axis_block_sig_gen.sv
// Per-channel stream-blocked flags, first-blocked-channel capture and
// running maximum stall depth for the deadlock monitors.
module axis_block_sig_gen
  import axis_mon_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = CNT_W_DEF,
  localparam int CH_W        = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_is_read,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              first_block_valid,
  output logic [CH_W-1:0]   first_block_ch,
  output logic [CNT_W-1:0]  stall_max
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(STALL_THRESH);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_next;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]            rise;
  logic                         any_rise;
  logic [CH_W-1:0]              rise_ch;
  logic [CNT_W-1:0]             cur_max;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axis_stall_counter #(
      .CNT_W        (CNT_W),
      .STALL_THRESH (STALL_THRESH)
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .valid    (ch_valid[i]),
      .ready    (ch_ready[i]),
      .is_read  (ch_is_read[i]),
      .enable   (enable),
      .clear    (clear),
      .cnt_next (cnt_next[i]),
      .cnt      (cnt[i]),
      .flag     (axis_block_sigs[i])
    );
    // Flag always tracks cnt >= THR, so a 0->1 flag edge is a threshold crossing.
    assign rise[i] = enable && !clear && (cnt_next[i] >= THR) && (cnt[i] < THR);
  end

  always_comb begin
    any_rise = |rise;
    rise_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (rise[i]) rise_ch = CH_W'(i);
  end

  always_comb begin
    cur_max = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (cnt_next[i] > cur_max) cur_max = cnt_next[i];
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      first_block_valid <= 1'b0;
      first_block_ch    <= '0;
      stall_max         <= '0;
    end else begin
      if (!first_block_valid && any_rise) begin
        first_block_valid <= 1'b1;
        first_block_ch    <= rise_ch;
      end
      if (cur_max > stall_max) stall_max <= cur_max;
    end
  end

endmodule

// File: tb/tb_axis_block_sig_gen.sv
// Directed bench for axis_block_sig_gen: default config plus a narrow-counter
// instance for saturation.
module tb_axis_block_sig_gen;

  logic       clock = 1'b0;
  logic       reset, enable, clear;
  logic [2:0] ch_valid, ch_ready, ch_is_read;
  logic [2:0] sigs;
  logic       fbv;
  logic [1:0] fbc;
  logic [15:0] smax;

  logic       b_reset, b_enable, b_clear;
  logic [2:0] b_valid, b_ready, b_is_read;
  logic [2:0] b_sigs;
  logic       b_fbv;
  logic [1:0] b_fbc;
  logic [3:0] b_smax;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  axis_block_sig_gen #(.NUM_CH(3), .STALL_THRESH(16), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_is_read(ch_is_read),
    .axis_block_sigs(sigs), .first_block_valid(fbv), .first_block_ch(fbc),
    .stall_max(smax)
  );

  axis_block_sig_gen #(.NUM_CH(3), .STALL_THRESH(15), .CNT_W(4)) dut_b (
    .clock(clock), .reset(b_reset), .enable(b_enable), .clear(b_clear),
    .ch_valid(b_valid), .ch_ready(b_ready), .ch_is_read(b_is_read),
    .axis_block_sigs(b_sigs), .first_block_valid(b_fbv), .first_block_ch(b_fbc),
    .stall_max(b_smax)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    ch_valid = '0; ch_ready = '0; ch_is_read = '0;
    b_reset = 1'b1; b_enable = 1'b0; b_clear = 1'b0;
    b_valid = '0; b_ready = '0; b_is_read = '0;
    step(2);
    chk("rst_sigs", 32'(sigs), 0);
    chk("rst_fbv",  32'(fbv), 0);
    chk("rst_fbc",  32'(fbc), 0);
    chk("rst_max",  32'(smax), 0);

    // 1: ch0 write-side back-pressure
    reset = 1'b0; enable = 1'b1;
    ch_valid = 3'b001; ch_ready = 3'b000;
    step(15);
    chk("t1_sigs_15", 32'(sigs), 0);
    chk("t1_fbv_15",  32'(fbv), 0);
    step(1);
    chk("t1_sigs_16", 32'(sigs), 3'b001);
    chk("t1_fbv_16",  32'(fbv), 1);
    chk("t1_fbc_16",  32'(fbc), 0);

    // 2: one transfer cycle drops the flag
    ch_ready = 3'b001;
    step(1);
    chk("t2_sigs", 32'(sigs), 0);
    chk("t2_fbv",  32'(fbv), 1);
    chk("t2_fbc",  32'(fbc), 0);
    chk("t2_max",  32'(smax), 16);

    // 3: clear, then ch1 and ch2 starved on the read side together
    ch_valid = 3'b000; ch_ready = 3'b000;
    clear = 1'b1;
    step(1);
    chk("t3_clr_fbv", 32'(fbv), 0);
    chk("t3_clr_max", 32'(smax), 0);
    clear = 1'b0;
    ch_is_read = 3'b110; ch_ready = 3'b110;
    step(15);
    chk("t3_sigs_15", 32'(sigs), 0);
    step(1);
    chk("t3_sigs_16", 32'(sigs), 3'b110);
    chk("t3_fbv",     32'(fbv), 1);
    chk("t3_fbc",     32'(fbc), 1);
    ch_ready = 3'b000;
    step(1);
    chk("t3_idle_sigs", 32'(sigs), 0);

    // 4: enable=0 holds the count without flagging
    ch_valid = 3'b001;
    step(10);
    chk("t4_sigs_10", 32'(sigs), 0);
    enable = 1'b0;
    step(5);
    chk("t4_hold_sigs", 32'(sigs), 0);
    chk("t4_hold_max",  32'(smax), 16);
    enable = 1'b1;
    step(5);
    chk("t4_sigs_15", 32'(sigs), 0);
    step(1);
    chk("t4_sigs_16", 32'(sigs), 3'b001);
    chk("t4_fbc",     32'(fbc), 1);
    step(1);
    chk("t4_max_17",  32'(smax), 17);

    // 5: clear while stalled, then recount from zero
    step(3);
    chk("t5_max_20", 32'(smax), 20);
    clear = 1'b1;
    step(1);
    chk("t5_clr_sigs", 32'(sigs), 0);
    chk("t5_clr_fbv",  32'(fbv), 0);
    chk("t5_clr_fbc",  32'(fbc), 0);
    chk("t5_clr_max",  32'(smax), 0);
    clear = 1'b0;
    step(15);
    chk("t5_sigs_15", 32'(sigs), 0);
    step(1);
    chk("t5_sigs_16", 32'(sigs), 3'b001);
    chk("t5_fbv",     32'(fbv), 1);
    chk("t5_fbc",     32'(fbc), 0);
    // direction flip mid-stall keeps counting
    ch_is_read = 3'b111; ch_valid = 3'b000; ch_ready = 3'b001;
    step(1);
    chk("t5_flip_sigs", 32'(sigs), 3'b001);
    chk("t5_flip_max",  32'(smax), 17);

    // 6: narrow counter saturation, then reset mid-stall
    b_reset = 1'b0; b_enable = 1'b1;
    b_valid = 3'b001; b_ready = 3'b000;
    step(14);
    chk("t6_sigs_14", 32'(b_sigs), 0);
    step(1);
    chk("t6_sigs_15", 32'(b_sigs), 3'b001);
    chk("t6_fbv_15",  32'(b_fbv), 1);
    chk("t6_max_15",  32'(b_smax), 15);
    step(25);
    chk("t6_sigs_40", 32'(b_sigs), 3'b001);
    chk("t6_max_40",  32'(b_smax), 15);
    b_reset = 1'b1;
    step(1);
    chk("t6_rst_sigs", 32'(b_sigs), 0);
    chk("t6_rst_fbv",  32'(b_fbv), 0);
    chk("t6_rst_max",  32'(b_smax), 0);
    b_reset = 1'b0;
    step(1);
    chk("t6_resume_sigs", 32'(b_sigs), 0);
    chk("t6_resume_max",  32'(b_smax), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
